// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path (state encoding, parity).
package uart_pkg;

    localparam int unsigned MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic logic even_parity(input logic [MAX_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: one-cycle bit_end_o pulse every BAUD_DIV cycles while enabled.
module uart_baud_gen #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic bit_end_o
);

    logic [15:0] cnt_q, cnt_d;
    logic        term;

    assign term      = (cnt_q == 16'(BAUD_DIV - 1));
    assign bit_end_o = en_i && term;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || term) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: START, DATA (LSB first), optional even PARITY, STOP bits.
// Define UART_TX_BUF_EN to add a one-entry holding register for gapless frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV      = 434,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned ENABLE_PARITY = 1,
    parameter int unsigned STOP_BIT      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned FRAME_BITS = 1 + DATA_BITS + ENABLE_PARITY + STOP_BIT;
    // Sized from the frame length, which always exceeds DATA_BITS-1.
    localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);

    tx_state_t              state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   parity_q, parity_d;
    logic                   tx_q, tx_d;
    logic                   bit_end;
    logic                   accept;
    logic                   load;
    logic [DATA_BITS-1:0]   load_data;
`ifdef UART_TX_BUF_EN
    logic [DATA_BITS-1:0]   hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
`endif

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (state_q != IDLE),
        .bit_end_o (bit_end)
    );

`ifdef UART_TX_BUF_EN
    assign tx_ready = !hold_full_q;
`else
    assign tx_ready = (state_q == IDLE);
`endif
    assign accept = tx_valid && tx_ready;
    assign busy   = (state_q != IDLE);
    assign tx     = tx_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        load       = 1'b0;
        load_data  = tx_data;
`ifdef UART_TX_BUF_EN
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (accept && state_q != IDLE) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                        state_d    = (ENABLE_PARITY != 0) ? PARITY : STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_cnt_q == 1'(STOP_BIT - 1)) begin
                        state_d = IDLE;
`ifdef UART_TX_BUF_EN
                        // A byte accepted on the final stop cycle skips the holding register.
                        if (hold_full_q) begin
                            load        = 1'b1;
                            load_data   = hold_q;
                            state_d     = START;
                            hold_full_d = accept;
                        end else if (accept) begin
                            load        = 1'b1;
                            state_d     = START;
                            hold_full_d = 1'b0;
                        end
`endif
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shift_d  = load_data;
            parity_d = even_parity(MAX_DATA_BITS'(load_data));
        end

        // tx is registered from the next state so the line changes on the state edge.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            parity_q    <= 1'b0;
            tx_q        <= 1'b1;
`ifdef UART_TX_BUF_EN
            hold_q      <= '0;
            hold_full_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            parity_q    <= parity_d;
            tx_q        <= tx_d;
`ifdef UART_TX_BUF_EN
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four parameter sets, frame shape, handshake and reset.
// Expectations follow UART_TX_BUF_EN when the bench is built with it.
module tb_uart_tx;

`ifdef UART_TX_BUF_EN
    localparam logic RDY_IN_FRAME = 1'b1;
    localparam int   B2B_PERIOD   = 44;
`else
    localparam logic RDY_IN_FRAME = 1'b0;
    localparam int   B2B_PERIOD   = 45;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] valid_r;
    logic [7:0] data_r [4];
    logic [3:0] tx_w;
    logic [3:0] rdy_w;
    logic [3:0] busy_w;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic txv   [256];
    logic txlog [160];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: parity, 1 stop; 1: no parity; 2: two stop bits; 3: BAUD_DIV=16 loopback
    uart_tx #(.BAUD_DIV(4), .DATA_BITS(8), .ENABLE_PARITY(1), .STOP_BIT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid_r[0]), .tx_data(data_r[0]),
        .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));
    uart_tx #(.BAUD_DIV(4), .DATA_BITS(8), .ENABLE_PARITY(0), .STOP_BIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid_r[1]), .tx_data(data_r[1]),
        .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));
    uart_tx #(.BAUD_DIV(4), .DATA_BITS(8), .ENABLE_PARITY(1), .STOP_BIT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid_r[2]), .tx_data(data_r[2]),
        .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));
    uart_tx #(.BAUD_DIV(16), .DATA_BITS(8), .ENABLE_PARITY(1), .STOP_BIT(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid_r[3]), .tx_data(data_r[3]),
        .tx_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int bd_of(input int k);
        return (k == 3) ? 16 : 4;
    endfunction

    // Line levels of a frame, bit 0 = start; every bit above the used length is 1.
    function automatic logic [12:0] exp_frame(input logic [7:0] b, input bit par);
        logic [12:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
        if (par) f[9] = ^b;
        return f;
    endfunction

    task automatic run_frame(input int k, input logic [7:0] b, input int nbits,
                             input bit par, input string tag);
        int          bd;
        int          n;
        logic [12:0] ef;
        bit          busy_ok;
        bit          rdy_ok;
        bd      = bd_of(k);
        n       = nbits * bd;
        ef      = exp_frame(b, par);
        busy_ok = 1'b1;
        rdy_ok  = 1'b1;
        @(negedge clk);
        check({tag, " idle tx"}, tx_w[k], 1);
        check({tag, " idle ready"}, rdy_w[k], 1);
        valid_r[k] = 1'b1;
        data_r[k]  = b;
        @(negedge clk);
        valid_r[k] = 1'b0;
        data_r[k]  = ~b;
        for (int c = 0; c < n; c++) begin
            txv[c] = tx_w[k];
            if (busy_w[k] !== 1'b1) busy_ok = 1'b0;
            if (rdy_w[k] !== RDY_IN_FRAME) rdy_ok = 1'b0;
            @(negedge clk);
        end
        check({tag, " busy through frame"}, busy_ok, 1);
        check({tag, " ready during frame"}, rdy_ok, 1);
        check({tag, " busy after frame"}, busy_w[k], 0);
        check({tag, " ready after frame"}, rdy_w[k], 1);
        for (int i = 0; i < nbits; i++) begin
            check($sformatf("%s bit%0d", tag, i), {txv[i*bd], txv[i*bd+bd-1]}, {2{ef[i]}});
        end
    endtask

    task automatic decode_log(input int s, output logic [7:0] v);
        for (int j = 0; j < 8; j++) v[j] = txlog[s + 4*(1+j) + 2];
    endtask

    initial begin
        int         sent;
        int         f1;
        int         f2;
        logic       acc;
        logic [7:0] rx;

        rst_n   = 1'b0;
        valid_r = '0;
        for (int k = 0; k < 4; k++) data_r[k] = 8'h00;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset tx%0d", k), tx_w[k], 1);
            check($sformatf("reset ready%0d", k), rdy_w[k], 1);
            check($sformatf("reset busy%0d", k), busy_w[k], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(0, 8'hA5, 11, 1'b1, "A5 par");
        run_frame(0, 8'h01, 11, 1'b1, "01 par");
        run_frame(0, 8'h00, 11, 1'b1, "00 par");
        run_frame(1, 8'h01, 10, 1'b0, "01 nopar");
        run_frame(2, 8'hFF, 12, 1'b1, "FF 2stop");

        // Back-to-back on DUT 0 with the source holding valid until each accept.
        @(negedge clk);
        sent       = 0;
        valid_r[0] = 1'b1;
        data_r[0]  = 8'h11;
        for (int c = 0; c < 140; c++) begin
            txlog[c] = tx_w[0];
            acc      = valid_r[0] && rdy_w[0];
            @(negedge clk);
            if (acc) begin
                sent++;
                if (sent == 1) data_r[0] = 8'h22;
                else valid_r[0] = 1'b0;
            end
        end
        valid_r[0] = 1'b0;
        check("b2b accepts", sent, 2);
        f1 = -1;
        f2 = -1;
        for (int c = 1; c < 140; c++)
            if (f1 < 0 && txlog[c-1] == 1'b1 && txlog[c] == 1'b0) f1 = c;
        if (f1 >= 0)
            for (int c = f1 + 40; c < 140; c++)
                if (f2 < 0 && txlog[c-1] == 1'b1 && txlog[c] == 1'b0) f2 = c;
        if (f1 < 0 || f2 < 0 || f2 + 40 >= 140) begin
            check("b2b frames found", 0, 1);
        end else begin
            check("b2b period", f2 - f1, B2B_PERIOD);
            decode_log(f1, rx);
            check("b2b byte1", rx, 8'h11);
            decode_log(f2, rx);
            check("b2b byte2", rx, 8'h22);
        end
        repeat (50) @(negedge clk);

        // Reset during data bit 3 of an abandoned frame (0xF7 has bit3 = 0).
        valid_r[0] = 1'b1;
        data_r[0]  = 8'hF7;
        @(negedge clk);
        valid_r[0] = 1'b0;
        repeat (17) @(negedge clk);
        check("pre-reset bit3", tx_w[0], 0);
        #2 rst_n = 1'b0;
        #1;
        check("async reset tx", tx_w[0], 1);
        check("async reset busy", busy_w[0], 0);
        check("async reset ready", rdy_w[0], 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(0, 8'h5A, 11, 1'b1, "5A post-reset");

        // Loopback: receiver model samples DUT 3 mid-bit.
        run_frame(3, 8'h3C, 11, 1'b1, "3C loop");
        for (int j = 0; j < 8; j++) rx[j] = txv[(1+j)*16 + 8];
        check("loop data", rx, 8'h3C);
        check("loop parity error", txv[9*16 + 8] ^ (^rx), 0);
        check("loop stop", txv[10*16 + 8], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter that serialises parallel bytes onto the TX line. It is the upstream counterpart of the uart_rx receiver and uses the same frame format and parameter set, so a uart_tx/uart_rx pair with matching parameters loops back losslessly. Bytes come in through a valid/ready handshake from the fabric, for example a command source or a loopback from uart_rx data_out.

Parameters:
BAUD_DIV, 434, clock cycles per bit; legal range 2..65535 (16-bit baud counter).
DATA_BITS, 8, data bits per frame; legal range 5..9.
ENABLE_PARITY, 1, 1 = insert an even parity bit after the data bits; 0 = no parity bit.
STOP_BIT, 1, number of stop bits; legal range 1..2.

Ports:
clk  input  1  system clock; single clock domain.
rst_n  input  1  asynchronous, active-low reset.
tx_valid  input  1  tx_data holds a byte to send.
tx_data  input  DATA_BITS  byte to transmit, LSB first.
tx_ready  output  1  block can accept a byte this cycle.
tx  output  1  serial line; idles high; registered output, no glitches.
busy  output  1  a frame is on the line (START through the final STOP).

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset values: tx=1, tx_ready=1, busy=0. FSM goes to IDLE. Baud, bit and stop counters clear to 0.
- Reset mid-frame: tx returns high immediately (asynchronously). The partial frame is abandoned; there is no resume.
- Handshake: a transfer happens on a cycle where tx_valid && tx_ready. tx_data is captured into the shift register on that edge.
- tx_data need not stay stable after the transfer cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, busy=0, tx_ready=1.
  - On a transfer, the next cycle enters START with tx=0 and busy=1.
  - Latency from the transfer edge to the falling edge of tx is 1 cycle.
- Bit timing: each non-IDLE state holds tx for exactly BAUD_DIV cycles. The baud counter counts 0..BAUD_DIV-1 and advances the state at terminal count.
- START: drives tx=0 for one bit period, then goes to DATA.
- DATA:
  - Drives shift[0], then shifts right at each bit boundary.
  - The bit counter counts 0..DATA_BITS-1.
  - After the last bit: goes to PARITY if ENABLE_PARITY, otherwise to STOP.
- PARITY: drives the XOR of the captured data (even parity, matching uart_rx's check), then goes to STOP.
- STOP:
  - Drives tx=1 for STOP_BIT bit periods; the stop counter counts 0..STOP_BIT-1.
  - After the last stop bit, goes to IDLE (or see the optional feature).
- Frame length: N = (1 + DATA_BITS + ENABLE_PARITY + STOP_BIT) * BAUD_DIV cycles.
- Back-to-back transfers without the optional feature: tx_ready is low from START through STOP. The frame-to-frame period is N+1 cycles, because of one IDLE cycle at tx=1.
- tx_valid asserted while tx_ready=0 has no effect. The source holds tx_valid and tx_data until it sees tx_ready.

Optional Feature:
UART_TX_BUF_EN
- Defined: adds a one-entry holding register.
  - tx_ready = holding register empty, so a byte can be accepted during a frame.
  - At the end of the last stop bit, a full holding register goes straight to START in the next cycle (no IDLE cycle), which empties the register. Back-to-back period is exactly N.
  - In IDLE, an accepted byte bypasses the holding register and loads the shifter directly.
  - Accept and drain in the same cycle are legal: the register refills, and tx_ready stays 0 only while it is full.
- Undefined: no holding register; behaviour is as in Behaviour above.

Decomposition:
- Package uart_pkg:
  - State enum tx_state_t {IDLE, START, DATA, PARITY, STOP}, 3 bits.
  - Localparam FRAME_BITS = 1 + DATA_BITS + ENABLE_PARITY + STOP_BIT, computed in the module from its parameters.
  - Parity function even_parity(data).
- One sub-module, uart_baud_gen:
  - Counter that emits a one-cycle bit_end pulse every BAUD_DIV cycles while enabled.
  - Cleared when disabled or on rst_n.

Test Plan:
- Basic frame: BAUD_DIV=4, parity on, 1 stop. Send 0xA5. Required tx sampled every 4 cycles: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1. Frame is 44 cycles; tx falls 1 cycle after accept.
- Parity polarity: send 0x01 (parity on) -> parity bit 1. Send 0x00 -> parity bit 0. With ENABLE_PARITY=0, send 0x01 -> stop bit follows data bit 7 directly; frame is 40 cycles.
- Two stop bits: STOP_BIT=2, send 0xFF -> tx is high for 8 cycles after data/parity. tx_ready returns 1 exactly at frame end + 1.
- Back-to-back: tx_valid held high for 0x11 then 0x22. Period between falling edges is 45 cycles without UART_TX_BUF_EN and 44 cycles with it. No byte is lost or duplicated.
- Reset mid-frame: assert rst_n=0 during data bit 3 -> tx=1, busy=0, tx_ready=1 the same cycle. After release, 0x5A transmits as a clean frame.
- Loopback: uart_tx.tx feeds uart_rx.rx with matching parameters (BAUD_DIV=16). Send 0x3C -> uart_rx data_out=0x3C, error=0, ready returns to 1.
